// File: rtl/mips_branch_pkg.sv
// Shared types and constants for the ID-stage branch resolution logic.
package mips_branch_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        EVAL  = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic stage_hit(input logic             wr,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] src);
        return wr && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational hazard check for the ID branch comparator: stall requirement
// and per-operand forwarding selects from the EX/MEM/WB stage state.
module branch_hazard_detect
    import mips_branch_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             exRegWrite_i,
    input  logic             exMemRead_i,
    input  logic [REG_W-1:0] exRd_i,
    input  logic             memRegWrite_i,
    input  logic             memMemRead_i,
    input  logic [REG_W-1:0] memRd_i,
    input  logic             wbRegWrite_i,
    input  logic [REG_W-1:0] wbRd_i,
    output logic [1:0]       stallReq_o,
    output logic [1:0]       fwdRsSel_o,
    output logic [1:0]       fwdRtSel_o
);

    logic exRs, exRt, memRs, memRt, wbRs, wbRt;
    logic exMatch, memMatch;

    always_comb begin
        exRs  = stage_hit(exRegWrite_i, exRd_i, rs_i);
        exRt  = stage_hit(exRegWrite_i, exRd_i, rt_i);
        memRs = stage_hit(memRegWrite_i, memRd_i, rs_i);
        memRt = stage_hit(memRegWrite_i, memRd_i, rt_i);
        wbRs  = stage_hit(wbRegWrite_i, wbRd_i, rs_i);
        wbRt  = stage_hit(wbRegWrite_i, wbRd_i, rt_i);

        exMatch  = exRs | exRt;
        memMatch = memRs | memRt;

        stallReq_o = 2'd0;
        if (exMatch && exMemRead_i) begin
            stallReq_o = 2'd2;
        end else if ((exMatch && !exMemRead_i) || (memMatch && memMemRead_i)) begin
            stallReq_o = 2'd1;
        end

        // A MEM-stage load has no ALU result yet, so only a MEM ALU op forwards.
        fwdRsSel_o = FWD_REGFILE;
        if (memRs && !memMemRead_i) fwdRsSel_o = FWD_MEM;
        else if (wbRs)              fwdRsSel_o = FWD_WB;

        fwdRtSel_o = FWD_REGFILE;
        if (memRt && !memMemRead_i) fwdRtSel_o = FWD_MEM;
        else if (wbRt)              fwdRtSel_o = FWD_WB;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage BEQ/BNE sequencer: stalls on in-flight dependencies, then drives
// taken / PC-select / IF-ID flush. Define BRANCH_RESOLVE_STATS_EN for counters.
module branch_resolve_ctrl
    import mips_branch_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             idValidInput,
    input  logic             idIsBeqInput,
    input  logic             idIsBneInput,
    input  logic [REG_W-1:0] idRsInput,
    input  logic [REG_W-1:0] idRtInput,
    input  logic             exRegWriteInput,
    input  logic             exMemReadInput,
    input  logic [REG_W-1:0] exRdInput,
    input  logic             memRegWriteInput,
    input  logic             memMemReadInput,
    input  logic [REG_W-1:0] memRdInput,
    input  logic             wbRegWriteInput,
    input  logic [REG_W-1:0] wbRdInput,
    input  logic             zeroTestInput,
    output logic             stallOutput,
    output logic [1:0]       forwardRsSelOutput,
    output logic [1:0]       forwardRtSelOutput,
    output logic             branchTakenOutput,
    output logic             pcSrcOutput,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [DATA_W-1:0] branchCountOutput,
    output logic [DATA_W-1:0] takenCountOutput,
    output logic [DATA_W-1:0] stallCycleCountOutput,
`endif
    output logic             flushIfIdOutput
);

    state_e     state_q, state_d;
    logic [1:0] stallCnt_q, stallCnt_d;
    logic [1:0] stallReq, fwdRs, fwdRt;
    logic       isBranch, stall, taken, resolved;

    branch_hazard_detect u_hazard (
        .rs_i          (idRsInput),
        .rt_i          (idRtInput),
        .exRegWrite_i  (exRegWriteInput),
        .exMemRead_i   (exMemReadInput),
        .exRd_i        (exRdInput),
        .memRegWrite_i (memRegWriteInput),
        .memMemRead_i  (memMemReadInput),
        .memRd_i       (memRdInput),
        .wbRegWrite_i  (wbRegWriteInput),
        .wbRd_i        (wbRdInput),
        .stallReq_o    (stallReq),
        .fwdRsSel_o    (fwdRs),
        .fwdRtSel_o    (fwdRt)
    );

    always_comb begin
        isBranch   = idValidInput & (idIsBeqInput | idIsBneInput);
        state_d    = state_q;
        stallCnt_d = stallCnt_q;
        stall      = 1'b0;
        taken      = 1'b0;
        resolved   = 1'b0;

        unique case (state_q)
            EVAL: begin
                if (isBranch) begin
                    if (stallReq != 2'd0) begin
                        stall      = 1'b1;
                        stallCnt_d = stallReq - 2'd1;
                        if (stallReq > 2'd1) state_d = STALL;
                    end else begin
                        resolved = 1'b1;
                        // BEQ wins when both type bits are set.
                        taken    = idIsBeqInput ? zeroTestInput : ~zeroTestInput;
                    end
                end
            end
            STALL: begin
                if (!idValidInput) begin
                    state_d    = EVAL;
                    stallCnt_d = '0;
                end else begin
                    stall = 1'b1;
                    if (stallCnt_q <= 2'd1) begin
                        state_d    = EVAL;
                        stallCnt_d = '0;
                    end else begin
                        stallCnt_d = stallCnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d    = EVAL;
                stallCnt_d = '0;
            end
        endcase

        // Everything is held quiet while reset is asserted.
        if (reset) begin
            stall    = 1'b0;
            taken    = 1'b0;
            resolved = 1'b0;
        end
    end

    assign stallOutput        = stall;
    assign forwardRsSelOutput = reset ? FWD_REGFILE : fwdRs;
    assign forwardRtSelOutput = reset ? FWD_REGFILE : fwdRt;
    assign branchTakenOutput  = taken;
    assign pcSrcOutput        = taken;
    assign flushIfIdOutput    = taken;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= EVAL;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [DATA_W-1:0] branchCnt_q, takenCnt_q, stallCycCnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            branchCnt_q   <= '0;
            takenCnt_q    <= '0;
            stallCycCnt_q <= '0;
        end else begin
            if (resolved) branchCnt_q   <= branchCnt_q + 32'd1;
            if (taken)    takenCnt_q    <= takenCnt_q + 32'd1;
            if (stall)    stallCycCnt_q <= stallCycCnt_q + 32'd1;
        end
    end

    assign branchCountOutput     = branchCnt_q;
    assign takenCountOutput      = takenCnt_q;
    assign stallCycleCountOutput = stallCycCnt_q;
`else
    logic unusedResolved;
    assign unusedResolved = resolved;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed vectors push expected
// outputs; a negedge monitor pops and compares each cycle.
module tb_branch_resolve_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       idValidInput, idIsBeqInput, idIsBneInput;
    logic [4:0] idRsInput, idRtInput;
    logic       exRegWriteInput, exMemReadInput;
    logic [4:0] exRdInput;
    logic       memRegWriteInput, memMemReadInput;
    logic [4:0] memRdInput;
    logic       wbRegWriteInput;
    logic [4:0] wbRdInput;
    logic       zeroTestInput;
    logic       stallOutput;
    logic [1:0] forwardRsSelOutput, forwardRtSelOutput;
    logic       branchTakenOutput, pcSrcOutput, flushIfIdOutput;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] branchCountOutput, takenCountOutput, stallCycleCountOutput;
`endif

    branch_resolve_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .idValidInput       (idValidInput),
        .idIsBeqInput       (idIsBeqInput),
        .idIsBneInput       (idIsBneInput),
        .idRsInput          (idRsInput),
        .idRtInput          (idRtInput),
        .exRegWriteInput    (exRegWriteInput),
        .exMemReadInput     (exMemReadInput),
        .exRdInput          (exRdInput),
        .memRegWriteInput   (memRegWriteInput),
        .memMemReadInput    (memMemReadInput),
        .memRdInput         (memRdInput),
        .wbRegWriteInput    (wbRegWriteInput),
        .wbRdInput          (wbRdInput),
        .zeroTestInput      (zeroTestInput),
        .stallOutput        (stallOutput),
        .forwardRsSelOutput (forwardRsSelOutput),
        .forwardRtSelOutput (forwardRtSelOutput),
        .branchTakenOutput  (branchTakenOutput),
        .pcSrcOutput        (pcSrcOutput),
`ifdef BRANCH_RESOLVE_STATS_EN
        .branchCountOutput     (branchCountOutput),
        .takenCountOutput      (takenCountOutput),
        .stallCycleCountOutput (stallCycleCountOutput),
`endif
        .flushIfIdOutput    (flushIfIdOutput)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] v;   // {stall, fwdRs, fwdRt, taken, pcSrc, flush}
    } exp_t;

    exp_t expq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk(e.name, {24'd0, stallOutput, forwardRsSelOutput, forwardRtSelOutput,
                         branchTakenOutput, pcSrcOutput, flushIfIdOutput}, {24'd0, e.v});
        end
    end

    task automatic idle();
        idValidInput = 0; idIsBeqInput = 0; idIsBneInput = 0;
        idRsInput = 0; idRtInput = 0;
        exRegWriteInput = 0; exMemReadInput = 0; exRdInput = 0;
        memRegWriteInput = 0; memMemReadInput = 0; memRdInput = 0;
        wbRegWriteInput = 0; wbRdInput = 0; zeroTestInput = 0;
    endtask

    task automatic br(input logic beq, input logic bne, input logic [4:0] rs,
                      input logic [4:0] rt, input logic z);
        idle();
        idValidInput = 1; idIsBeqInput = beq; idIsBneInput = bne;
        idRsInput = rs; idRtInput = rt; zeroTestInput = z;
    endtask

    // Expected values for the cycle whose inputs are currently driven.
    task automatic step(input string nm, input logic s, input logic [1:0] fa,
                        input logic [1:0] fb, input logic t);
        exp_t e;
        e.name = nm;
        e.v    = {s, fa, fb, t, t, t};
        expq.push_back(e);
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1; idle();
        @(posedge clock); #1;

        step("rst_idle", 0, 0, 0, 0);
        br(1, 0, 1, 2, 1); memRegWriteInput = 1; memRdInput = 1;
        step("rst_gate", 0, 0, 0, 0);
        reset = 0; idle();
        step("post_rst", 0, 0, 0, 0);

        br(1, 0, 1, 2, 1);
        step("beq_clean", 0, 0, 0, 1);

        br(0, 1, 3, 4, 0); exRegWriteInput = 1; exMemReadInput = 1; exRdInput = 3;
        step("bne_exld_s1", 1, 0, 0, 0);
        br(0, 1, 3, 4, 0); memRegWriteInput = 1; memMemReadInput = 1; memRdInput = 3;
        step("bne_exld_s2", 1, 0, 0, 0);
        br(0, 1, 3, 4, 0); wbRegWriteInput = 1; wbRdInput = 3;
        step("bne_exld_res", 0, 2, 0, 1);

        br(1, 0, 5, 6, 0); exRegWriteInput = 1; exRdInput = 6;
        step("beq_exalu_s", 1, 0, 0, 0);
        br(1, 0, 5, 6, 0); memRegWriteInput = 1; memRdInput = 6;
        step("beq_exalu_res", 0, 0, 1, 0);

        br(1, 0, 0, 0, 1); exRegWriteInput = 1; exMemReadInput = 1;
        memRegWriteInput = 1; wbRegWriteInput = 1;
        step("beq_r0", 0, 0, 0, 1);

        br(1, 0, 7, 8, 1); memRegWriteInput = 1; memMemReadInput = 1; memRdInput = 8;
        step("beq_memld_s", 1, 0, 0, 0);
        br(1, 0, 7, 8, 1); wbRegWriteInput = 1; wbRdInput = 8;
        step("beq_memld_res", 0, 0, 2, 1);

        br(0, 1, 9, 10, 1); memRegWriteInput = 1; memRdInput = 9;
        wbRegWriteInput = 1; wbRdInput = 9;
        step("fwd_prio", 0, 1, 0, 0);

        br(1, 1, 11, 12, 1);
        step("both_bits_z1", 0, 0, 0, 1);
        br(1, 1, 11, 12, 0);
        step("both_bits_z0", 0, 0, 0, 0);

        idle(); idValidInput = 1; idRsInput = 13; idRtInput = 14; zeroTestInput = 1;
        exRegWriteInput = 1; exMemReadInput = 1; exRdInput = 13;
        memRegWriteInput = 1; memRdInput = 14;
        step("nonbr_haz", 0, 0, 1, 0);

        br(1, 0, 1, 2, 1); idValidInput = 0; wbRegWriteInput = 1; wbRdInput = 2;
        step("invalid_br", 0, 0, 2, 0);

        br(1, 0, 15, 16, 1); exRegWriteInput = 1; exMemReadInput = 1; exRdInput = 16;
        step("sq_s1", 1, 0, 0, 0);
        idValidInput = 0;
        step("sq_drop", 0, 0, 0, 0);
        br(1, 0, 15, 16, 1);
        step("sq_after", 0, 0, 0, 1);

        br(0, 1, 17, 18, 1); exRegWriteInput = 1; exMemReadInput = 1; exRdInput = 17;
        step("rst_s1", 1, 0, 0, 0);
        reset = 1;
        step("rst_in_stall", 0, 0, 0, 0);
        reset = 0; br(0, 1, 17, 18, 0);
        step("rst_after", 0, 0, 0, 1);

        // 3 branches, 2 taken, 3 stall cycles from a fresh reset.
        reset = 1; idle();
        step("stats_rst", 0, 0, 0, 0);
        reset = 0;
        br(0, 1, 3, 4, 0); exRegWriteInput = 1; exMemReadInput = 1; exRdInput = 3;
        step("st_a1", 1, 0, 0, 0);
        br(0, 1, 3, 4, 0); memRegWriteInput = 1; memMemReadInput = 1; memRdInput = 3;
        step("st_a2", 1, 0, 0, 0);
        br(0, 1, 3, 4, 0); wbRegWriteInput = 1; wbRdInput = 3;
        step("st_a3", 0, 2, 0, 1);
        br(1, 0, 5, 6, 0); exRegWriteInput = 1; exRdInput = 6;
        step("st_b1", 1, 0, 0, 0);
        br(1, 0, 5, 6, 0); memRegWriteInput = 1; memRdInput = 6;
        step("st_b2", 0, 0, 1, 0);
        br(1, 0, 1, 2, 1);
        step("st_c1", 0, 0, 0, 1);
        idle();
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("branch_count", branchCountOutput, 32'd3);
        chk("taken_count", takenCountOutput, 32'd2);
        chk("stall_cycles", stallCycleCountOutput, 32'd3);
`endif

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clock);
        #1;
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
